// File: rtl/pulse_interval_meter_if.sv
// Signal bundle between a pulse source / register block and pulse_interval_meter.
interface pulse_interval_meter_if;
  logic        en;
  logic        pulse_in;
  logic [15:0] period_us;
  logic        period_valid;
  logic        timeout;
  logic        active;

  // Side that enables the meter, supplies the pulse and consumes results
  modport master (
    output en,
    output pulse_in,
    input  period_us,
    input  period_valid,
    input  timeout,
    input  active
  );

  // The meter itself
  modport slave (
    input  en,
    input  pulse_in,
    output period_us,
    output period_valid,
    output timeout,
    output active
  );
endinterface

// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter: measures the interval between rising edges of an
// asynchronous pulse in whole microseconds and flags a stopped input.
module pulse_interval_meter #(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned TIMEOUT_US    = 50_000
) (
  input  logic                        clk,
  input  logic                        reset,
  pulse_interval_meter_if.slave       pim
);

  localparam int unsigned DIV   = CLK_FREQUENCY / 1_000_000;
  localparam int unsigned PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W = 16;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // Input conditioning
  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic edge_c;

  // FSM, prescaler, interval counter and registered outputs
  logic [0:0]       state_q,  state_d;
  logic [PS_W-1:0]  ps_q,     ps_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [15:0]      period_q, period_d;
  logic             valid_q,  valid_d;
  logic             tmo_q,    tmo_d;
  logic             active_q, active_d;
  logic             tick_c;
  logic             limit_c;

  // Two-flop synchronizer plus history flop; runs regardless of en so an
  // input already high at enable does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pim.pulse_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign edge_c  = s2_q & ~prev_q;
  assign tick_c  = (ps_q == PS_W'(DIV - 1));
  assign limit_c = ((17'(cnt_q) + 17'd1) == 17'(TIMEOUT_US));

  // Next-state and output decode; en low overrides everything and parks in IDLE
  always_comb begin
    state_d  = state_q;
    ps_d     = ps_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;

    if (!pim.en) begin
      state_d = ST_IDLE;
      ps_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ps_d  = '0;
          cnt_d = '0;
          if (edge_c) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (edge_c) begin
            // Edge wins over a coincident timeout tick; include the tick
            // completing in this cycle.
            period_d = cnt_q + CNT_W'(tick_c);
            valid_d  = 1'b1;
            cnt_d    = '0;
            ps_d     = '0;
          end else if (tick_c && limit_c) begin
            period_d = '0;
            tmo_d    = 1'b1;
            state_d  = ST_IDLE;
            cnt_d    = '0;
            ps_d     = '0;
          end else begin
            ps_d = tick_c ? '0 : ps_q + PS_W'(1);
            if (tick_c) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          ps_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end

    active_d = (state_d == ST_MEASURE);
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ps_q     <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ps_q     <= ps_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      active_q <= active_d;
    end
  end

  assign pim.period_us    = period_q;
  assign pim.period_valid = valid_q;
  assign pim.timeout      = tmo_q;
  assign pim.active       = active_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed bench for pulse_interval_meter: a 50 MHz instance with the default
// timeout and a second one with a 10 us timeout, sharing the same stimulus.
module tb_pulse_interval_meter;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic pulse;

  always #5 clk = ~clk;

  pulse_interval_meter_if ifa ();
  pulse_interval_meter_if ifb ();

  assign ifa.en       = en;
  assign ifa.pulse_in = pulse;
  assign ifb.en       = en;
  assign ifb.pulse_in = pulse;

  pulse_interval_meter #(.CLK_FREQUENCY(50_000_000), .TIMEOUT_US(50_000)) dut_a (
    .clk   (clk),
    .reset (reset),
    .pim   (ifa)
  );

  pulse_interval_meter #(.CLK_FREQUENCY(50_000_000), .TIMEOUT_US(10)) dut_b (
    .clk   (clk),
    .reset (reset),
    .pim   (ifb)
  );

  int nvec  = 0;
  int nmis  = 0;
  int since = 0;

  typedef struct {
    string       name;
    int          gap;
    int          hi;
    logic [15:0] exp_period;
    logic        exp_valid;
    logic        exp_active;
  } vec_t;

  vec_t tbl [8];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      since++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic get(input bit sel, output logic [15:0] p, output logic v,
                     output logic t, output logic a);
    if (sel) begin
      p = ifb.period_us; v = ifb.period_valid; t = ifb.timeout; a = ifb.active;
    end else begin
      p = ifa.period_us; v = ifa.period_valid; t = ifa.timeout; a = ifa.active;
    end
  endtask

  // Rising edge `gap` cycles after the previous one, held high `hi` cycles;
  // the strobe is expected 3 clk edges after the rise (2 after first sampling).
  task automatic do_edge(input bit sel, input int gap, input int hi,
                         input logic [15:0] ep, input logic ev, input logic ea,
                         input string nm);
    logic [15:0] p;
    logic v, t, a;
    while (since < gap) step(1);
    pulse = 1'b1;
    since = 0;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      if (c == hi) pulse = 1'b0;
      get(sel, p, v, t, a);
      if (c == 2) chk({nm, "_early_valid"}, 32'(v), 32'(0));
      if (c == 3) begin
        chk({nm, "_valid"},   32'(v), 32'(ev));
        chk({nm, "_period"},  32'(p), 32'(ep));
        chk({nm, "_active"},  32'(a), 32'(ea));
        chk({nm, "_timeout"}, 32'(t), 32'(0));
      end
      if (c == 4) chk({nm, "_late_valid"}, 32'(v), 32'(0));
    end
    if (hi > 4) begin
      step(hi - 4);
      pulse = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    since = 0;
  endtask

  logic [15:0] p;
  logic v, t, a;

  initial begin
    tbl[0] = '{"arm",    20,   4, 16'd0,   1'b0, 1'b1};
    tbl[1] = '{"p5000a", 5000, 4, 16'd100, 1'b1, 1'b1};
    tbl[2] = '{"p5000b", 5000, 4, 16'd100, 1'b1, 1'b1};
    tbl[3] = '{"p4999",  4999, 4, 16'd99,  1'b1, 1'b1};
    tbl[4] = '{"p5049",  5049, 4, 16'd100, 1'b1, 1'b1};
    tbl[5] = '{"p50",    50,   4, 16'd1,   1'b1, 1'b1};
    tbl[6] = '{"p49",    49,   4, 16'd0,   1'b1, 1'b1};
    tbl[7] = '{"p100",   100,  4, 16'd2,   1'b1, 1'b1};

    reset = 1'b1;
    en    = 1'b1;
    pulse = 1'b0;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      get(s[0], p, v, t, a);
      chk("rst_period",  32'(p), 32'(0));
      chk("rst_valid",   32'(v), 32'(0));
      chk("rst_timeout", 32'(t), 32'(0));
      chk("rst_active",  32'(a), 32'(0));
    end

    // Basic measurement and rounding on the long-timeout instance
    foreach (tbl[i])
      do_edge(1'b0, tbl[i].gap, tbl[i].hi, tbl[i].exp_period,
              tbl[i].exp_valid, tbl[i].exp_active, tbl[i].name);

    // Timeout on the 10 us instance
    do_reset();
    do_edge(1'b1, 20, 4, 16'd0, 1'b0, 1'b1, "t_arm");
    do_edge(1'b1, 100, 4, 16'd2, 1'b1, 1'b1, "t_meas");
    step(498);
    chk("t_pre_timeout", 32'(ifb.timeout), 32'(0));
    chk("t_pre_active",  32'(ifb.active),  32'(1));
    step(1);
    chk("t_timeout",     32'(ifb.timeout),      32'(1));
    chk("t_period_zero", 32'(ifb.period_us),    32'(0));
    chk("t_active_drop", 32'(ifb.active),       32'(0));
    chk("t_no_valid",    32'(ifb.period_valid), 32'(0));
    step(1);
    chk("t_one_cycle",   32'(ifb.timeout), 32'(0));
    do_edge(1'b1, since + 10, 4, 16'd0, 1'b0, 1'b1, "t_rearm");

    // Edge coincident with the timeout tick
    do_edge(1'b1, 500, 4, 16'd10, 1'b1, 1'b1, "edge_on_tick");
    chk("eot_no_timeout", 32'(ifb.timeout), 32'(0));
    chk("eot_active",     32'(ifb.active),  32'(1));

    // Enable control on the long-timeout instance
    do_reset();
    do_edge(1'b0, 20, 4, 16'd0, 1'b0, 1'b1, "c_arm");
    do_edge(1'b0, 200, 4, 16'd4, 1'b1, 1'b1, "c_meas");
    step(46);
    en = 1'b0;
    step(1);
    chk("c_en_low_active", 32'(ifa.active),    32'(0));
    chk("c_en_low_period", 32'(ifa.period_us), 32'(4));
    do_edge(1'b0, 100, 4, 16'd4, 1'b0, 1'b0, "c_dis1");
    do_edge(1'b0, 100, 4, 16'd4, 1'b0, 1'b0, "c_dis2");
    step(10);
    pulse = 1'b1;
    step(6);
    en = 1'b1;
    step(10);
    chk("c_high_at_en_active", 32'(ifa.active),       32'(0));
    chk("c_high_at_en_valid",  32'(ifa.period_valid), 32'(0));
    pulse = 1'b0;
    since = 0;
    step(5);
    do_edge(1'b0, 10, 4, 16'd4, 1'b0, 1'b1, "c_rearm");
    do_edge(1'b0, 100, 4, 16'd2, 1'b1, 1'b1, "c_after");

    // One-cycle reset in the middle of a measurement
    step(40);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    since = 0;
    chk("r_period",  32'(ifa.period_us),    32'(0));
    chk("r_valid",   32'(ifa.period_valid), 32'(0));
    chk("r_timeout", 32'(ifa.timeout),      32'(0));
    chk("r_active",  32'(ifa.active),       32'(0));
    do_edge(1'b0, 30, 4, 16'd0, 1'b0, 1'b1, "r_first");
    do_edge(1'b0, 100, 4, 16'd2, 1'b1, 1'b1, "r_second");

    // Single-clock-wide glitch counts as an edge
    do_edge(1'b0, 150, 1, 16'd3, 1'b1, 1'b1, "glitch");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
